// File: rtl/gate_tt_sequencer_if.sv
// Handshake and gate-drive bundle for gate_tt_sequencer.
// Optional first-fail report signals exist only when GATE_TT_FIRST_FAIL_EN is defined.
interface gate_tt_sequencer_if #(
  parameter int ERRW = 4
);
  logic            start;
  logic [2:0]      gate_sel;
  logic            dut_out;
  logic            A;
  logic            B;
  logic            busy;
  logic            done;
  logic            pass;
  logic [ERRW-1:0] err_count;
`ifdef GATE_TT_FIRST_FAIL_EN
  logic            fail_valid;
  logic [1:0]      fail_vec;

  modport master (
    output start, gate_sel, dut_out,
    input  A, B, busy, done, pass, err_count, fail_valid, fail_vec
  );
  modport slave (
    input  start, gate_sel, dut_out,
    output A, B, busy, done, pass, err_count, fail_valid, fail_vec
  );
`else
  modport master (
    output start, gate_sel, dut_out,
    input  A, B, busy, done, pass, err_count
  );
  modport slave (
    input  start, gate_sel, dut_out,
    output A, B, busy, done, pass, err_count
  );
`endif
endinterface

// File: rtl/gate_tt_sequencer.sv
// Truth-table self-test sequencer for one 2-input basic gate: sweeps {A,B}, samples after DWELL cycles,
// counts mismatches. Define GATE_TT_FIRST_FAIL_EN to add the fail_valid/fail_vec first-mismatch report.
module gate_tt_sequencer #(
  parameter int DWELL  = 2,
  parameter int REPEAT = 1,
  parameter int ERRW   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_tt_sequencer_if.slave   bus
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SW-1:0]   SWEEP_LAST = SW'(REPEAT - 1);
  localparam logic [ERRW-1:0] ERR_MAX    = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [1:0]      vec_q, vec_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [SW-1:0]   sweep_q, sweep_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [ERRW-1:0] err_q, err_d;
`ifdef GATE_TT_FIRST_FAIL_EN
  logic            fail_valid_q, fail_valid_d;
  logic [1:0]      fail_vec_q, fail_vec_d;
`endif

  // Expected gate output for vector index v = {A,B}.
  function automatic logic expected(input logic [2:0] sel, input logic [1:0] v);
    case (sel)
      3'd0:    expected = (v == 2'b11);
      3'd1:    expected = (v != 2'b00);
      3'd2:    expected = (v != 2'b11);
      3'd3:    expected = (v == 2'b00);
      3'd4:    expected = ^v;
      3'd5:    expected = ~^v;
      default: expected = 1'b0;
    endcase
  endfunction

  logic mismatch;
  assign mismatch = (bus.dut_out != expected(sel_q, vec_q));

  always_comb begin
    // NOTE: every _d defaults to its _q (done to 0) so no branch can leave one unassigned and infer a latch.
    state_d = state_q;
    sel_d   = sel_q;
    vec_d   = vec_q;
    dwell_d = dwell_q;
    sweep_d = sweep_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
`ifdef GATE_TT_FIRST_FAIL_EN
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pass_d = 1'b0;
`ifdef GATE_TT_FIRST_FAIL_EN
          fail_valid_d = 1'b0;
          fail_vec_d   = 2'b00;
`endif
          if (bus.gate_sel <= 3'd5) begin
            sel_d   = bus.gate_sel;
            err_d   = '0;
            vec_d   = 2'b00;
            dwell_d = '0;
            sweep_d = '0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            // Unknown gate type: report a full-scale failure without driving the gate.
            err_d   = ERR_MAX;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        dwell_d = dwell_q + DW'(1);
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          vec_d   = vec_q + 2'd1;
          if (mismatch && (err_q != ERR_MAX)) err_d = err_q + ERRW'(1);
`ifdef GATE_TT_FIRST_FAIL_EN
          if (mismatch && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
          end
`endif
          if (vec_q == 2'b11) begin
            if (sweep_q == SWEEP_LAST) begin
              busy_d  = 1'b0;
              state_d = DONE;
            end else begin
              sweep_d = sweep_q + SW'(1);
            end
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      vec_q   <= 2'b00;
      dwell_q <= '0;
      sweep_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
`ifdef GATE_TT_FIRST_FAIL_EN
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 2'b00;
`endif
    end else begin
      // NOTE: non-blocking so every flop captures values computed from the pre-edge state.
      state_q <= state_d;
      sel_q   <= sel_d;
      vec_q   <= vec_d;
      dwell_q <= dwell_d;
      sweep_q <= sweep_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
`ifdef GATE_TT_FIRST_FAIL_EN
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
`endif
    end
  end

  // A/B come straight from the vector register, which returns to 00 when a run ends.
  assign bus.A         = vec_q[1];
  assign bus.B         = vec_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
`ifdef GATE_TT_FIRST_FAIL_EN
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_vec   = fail_vec_q;
`endif

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench for gate_tt_sequencer: DWELL=2/REPEAT=1 and DWELL=2/REPEAT=2 instances,
// with behavioural gate models (good NOR/XOR, stuck-at-0/1) on dut_out.
module tb_gate_tt_sequencer;

  localparam logic [1:0] M_TIE0 = 2'd0, M_TIE1 = 2'd1, M_NOR = 2'd2, M_XOR = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_tt_sequencer_if #(.ERRW(4)) bus1 ();
  gate_tt_sequencer_if #(.ERRW(4)) bus2 ();

  logic [1:0] mode1, mode2;

  function automatic logic model(input logic [1:0] m, input logic a, input logic b);
    case (m)
      M_TIE0:  model = 1'b0;
      M_TIE1:  model = 1'b1;
      M_NOR:   model = ~(a | b);
      default: model = a ^ b;
    endcase
  endfunction

  always_comb bus1.dut_out = model(mode1, bus1.A, bus1.B);
  always_comb bus2.dut_out = model(mode2, bus2.A, bus2.B);

  gate_tt_sequencer #(.DWELL(2), .REPEAT(1), .ERRW(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  gate_tt_sequencer #(.DWELL(2), .REPEAT(2), .ERRW(4)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {A,B} and done after edges 0..10 of a DWELL=2, REPEAT=1 run.
  logic [1:0] exp_ab   [11] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
  logic       exp_busy [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       exp_done [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  // Pulse start on dut1; returns at the negedge following the accept edge (edge 0).
  task automatic start_run1(input logic [2:0] sel);
    @(negedge clk);
    bus1.gate_sel = sel;
    bus1.start    = 1'b1;
    @(negedge clk);
    bus1.start    = 1'b0;
  endtask

  // Step max_edges edges on dut1, recording the first edge with done high and whether busy rose.
  task automatic watch1(input int max_edges, output int done_edge, output logic busy_seen);
    done_edge = -1;
    busy_seen = 1'b0;
    for (int e = 1; e <= max_edges; e++) begin
      @(negedge clk);
      if (bus1.done && done_edge < 0) done_edge = e;
      if (bus1.busy) busy_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus1.A, bus1.B, bus1.busy, bus1.done, bus1.pass, bus1.err_count} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got A%b B%b busy%b done%b pass%b err%h, required all 0",
               bus1.A, bus1.B, bus1.busy, bus1.done, bus1.pass, bus1.err_count);
    end
`ifdef GATE_TT_FIRST_FAIL_EN
    n_checks++;
    if ({bus1.fail_valid, bus1.fail_vec} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_fail: got valid %b vec %b, required 0 00", bus1.fail_valid, bus1.fail_vec);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_nor_good();
    mode1 = M_NOR;
    start_run1(3'd3);
    for (int e = 0; e <= 10; e++) begin
      if (e > 0) @(negedge clk);
      n_checks++;
      if ({bus1.A, bus1.B} !== exp_ab[e]) begin
        n_fail++;
        $display("FAIL nor_ab edge %0d: got %b, required %b", e, {bus1.A, bus1.B}, exp_ab[e]);
      end
      n_checks++;
      if (bus1.busy !== exp_busy[e] || bus1.done !== exp_done[e]) begin
        n_fail++;
        $display("FAIL nor_busy_done edge %0d: got busy %b done %b, required %b %b",
                 e, bus1.busy, bus1.done, exp_busy[e], exp_done[e]);
      end
    end
    n_checks++;
    if (bus1.pass !== 1'b1 || bus1.err_count !== 4'h0) begin
      n_fail++;
      $display("FAIL nor_result: got pass %b err %h, required 1 0", bus1.pass, bus1.err_count);
    end
  endtask

  task automatic test_nor_stuck0();
    int   de;
    logic bs;
    mode1 = M_TIE0;
    start_run1(3'd3);
    watch1(12, de, bs);
    n_checks++;
    if (de !== 9 || bus1.err_count !== 4'h1 || bus1.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL nor_stuck0: got done_edge %0d err %h pass %b, required 9 1 0", de, bus1.err_count, bus1.pass);
    end
`ifdef GATE_TT_FIRST_FAIL_EN
    n_checks++;
    if (bus1.fail_valid !== 1'b1 || bus1.fail_vec !== 2'b00) begin
      n_fail++;
      $display("FAIL nor_stuck0_first: got valid %b vec %b, required 1 00", bus1.fail_valid, bus1.fail_vec);
    end
`endif
  endtask

  task automatic test_and_stuck1_repeat2();
    int de = -1;
    mode2 = M_TIE1;
    @(negedge clk);
    bus2.gate_sel = 3'd0;
    bus2.start    = 1'b1;
    @(negedge clk);
    bus2.start    = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (bus2.done && de < 0) de = e;
    end
    n_checks++;
    if (de !== 17) begin
      n_fail++;
      $display("FAIL and_rep2_latency: got done edge %0d, required 17", de);
    end
    n_checks++;
    if (bus2.err_count !== 4'h6 || bus2.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL and_rep2_result: got err %h pass %b, required 6 0", bus2.err_count, bus2.pass);
    end
`ifdef GATE_TT_FIRST_FAIL_EN
    n_checks++;
    if (bus2.fail_valid !== 1'b1 || bus2.fail_vec !== 2'b00) begin
      n_fail++;
      $display("FAIL and_rep2_first: got valid %b vec %b, required 1 00", bus2.fail_valid, bus2.fail_vec);
    end
`endif
  endtask

  task automatic test_illegal_sel();
    int   de;
    logic bs;
    start_run1(3'd7);
    n_checks++;
    if (bus1.busy !== 1'b0 || {bus1.A, bus1.B} !== 2'b00 || bus1.done !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_edge0: got busy %b AB %b done %b, required 0 00 0",
               bus1.busy, {bus1.A, bus1.B}, bus1.done);
    end
    watch1(4, de, bs);
    n_checks++;
    if (de !== 1 || bs !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_timing: got done edge %0d busy_seen %b, required 1 0", de, bs);
    end
    n_checks++;
    if (bus1.err_count !== 4'hF || bus1.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_result: got err %h pass %b, required f 0", bus1.err_count, bus1.pass);
    end
`ifdef GATE_TT_FIRST_FAIL_EN
    n_checks++;
    if (bus1.fail_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_fail_valid: got %b, required 0", bus1.fail_valid);
    end
`endif
  endtask

  task automatic test_ignore_start_and_reset();
    int   de = -1;
    logic bs;
    mode1 = M_NOR;
    start_run1(3'd3);
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (bus1.done && de < 0) de = e;
      // Re-pulse start with an illegal gate_sel so it is sampled at edge 4.
      bus1.start    = (e == 3);
      bus1.gate_sel = (e == 3) ? 3'd7 : 3'd3;
    end
    n_checks++;
    if (de !== 9 || bus1.pass !== 1'b1 || bus1.err_count !== 4'h0) begin
      n_fail++;
      $display("FAIL ignore_start: got done edge %0d pass %b err %h, required 9 1 0", de, bus1.pass, bus1.err_count);
    end
    start_run1(3'd3);
    repeat (5) @(negedge clk);
    n_checks++;
    if ({bus1.A, bus1.B} !== 2'b10 || bus1.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL prereset_state: got AB %b busy %b, required 10 1", {bus1.A, bus1.B}, bus1.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus1.A, bus1.B, bus1.busy, bus1.done, bus1.pass, bus1.err_count} !== 9'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got A%b B%b busy%b done%b pass%b err%h, required all 0",
               bus1.A, bus1.B, bus1.busy, bus1.done, bus1.pass, bus1.err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    watch1(12, de, bs);
    n_checks++;
    if (de !== -1 || bs !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: got done edge %0d busy_seen %b, required -1 0", de, bs);
    end
  endtask

  task automatic test_xor_rerun();
    int   de;
    logic bs;
    mode1 = M_XOR;
    start_run1(3'd4);
    watch1(12, de, bs);
    n_checks++;
    if (de !== 9 || bus1.pass !== 1'b1 || bus1.err_count !== 4'h0) begin
      n_fail++;
      $display("FAIL xor_good: got done edge %0d pass %b err %h, required 9 1 0", de, bus1.pass, bus1.err_count);
    end
    mode1 = M_TIE0;
    @(negedge clk);
    n_checks++;
    if (bus1.pass !== 1'b1) begin
      n_fail++;
      $display("FAIL xor_pass_held: got %b, required 1", bus1.pass);
    end
    start_run1(3'd4);
    n_checks++;
    if (bus1.pass !== 1'b0 || bus1.err_count !== 4'h0) begin
      n_fail++;
      $display("FAIL xor_accept_clear: got pass %b err %h, required 0 0", bus1.pass, bus1.err_count);
    end
    watch1(12, de, bs);
    n_checks++;
    if (de !== 9 || bus1.pass !== 1'b0 || bus1.err_count !== 4'h2) begin
      n_fail++;
      $display("FAIL xor_stuck0: got done edge %0d pass %b err %h, required 9 0 2", de, bus1.pass, bus1.err_count);
    end
`ifdef GATE_TT_FIRST_FAIL_EN
    n_checks++;
    if (bus1.fail_valid !== 1'b1 || bus1.fail_vec !== 2'b01) begin
      n_fail++;
      $display("FAIL xor_stuck0_first: got valid %b vec %b, required 1 01", bus1.fail_valid, bus1.fail_vec);
    end
`endif
  endtask

  initial begin
    mode1 = M_NOR;
    mode2 = M_TIE1;
    bus1.start = 1'b0;
    bus1.gate_sel = 3'd0;
    bus2.start = 1'b0;
    bus2.gate_sel = 3'd0;
    test_reset();
    test_nor_good();
    test_nor_stuck0();
    test_and_stuck1_repeat2();
    test_illegal_sel();
    test_ignore_start_and_reset();
    test_xor_rerun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_tt_sequencer.md
Name: gate_tt_sequencer

Overview:
- Controller that exhaustively exercises one 2-input basic gate, such as the NOR/AND/XOR cells in the Combinational Circuits library.
- Drives inputs A/B through all four combinations, waits a programmable settle time, samples the gate output, and compares it against the expected truth table for the selected gate type.
- Reports error count and pass/fail with a start/done handshake.
- Used as an in-design self-test sequencer for the basic-gate library.

Parameters:
DWELL, 2, cycles each vector is held before the gate output is sampled (legal range >=1)
REPEAT, 1, number of full 4-vector sweeps per run (legal range >=1)
ERRW, 4, width of err_count (saturating)

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  run request, sampled only in IDLE
gate_sel  input  3  gate type: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR; 6-7 illegal
dut_out  input  1  output of the gate under control
A  output  1  gate input A (MSB of vector index), registered
B  output  1  gate input B (LSB of vector index), registered
busy  output  1  high while sweeping
done  output  1  one-cycle pulse at end of run
pass  output  1  result of last run, held until next accepted start
err_count  output  ERRW  mismatches in last run, saturates at all-ones

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (async, immediate on rst_n low): state IDLE; A=0, B=0, busy=0, done=0, pass=0, err_count=0. Internal vec, dwell and sweep counters are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1 and legal gate_sel: latch gate_sel, clear err_count and pass, set vec=0 so that {A,B}=00, busy=1, and go to RUN.
  - On start=1 with illegal gate_sel: go to DONE directly, with err_count=all-ones, pass=0, and A/B unchanged at 0.
- RUN:
  - The dwell counter increments each cycle.
  - On the edge that ends the DWELL-th cycle of the current vector:
    - compare dut_out to expected(gate_sel_latched, A, B);
    - on mismatch, increment err_count, saturating at all-ones.
    - On that same edge, apply the next vector (vec+1) or, after vec=3, start the next sweep at vec=0.
  - Vector k is applied at edge t and sampled at edge t+DWELL.
  - After vec=3 of sweep REPEAT, go to DONE on the sampling edge with A=B=0 and busy=0.
- DONE: lasts exactly one cycle.
  - done=1 and pass=(err_count==0), where err_count includes the final sample.
  - Then return to IDLE. pass and err_count are held until the next accepted start.
- Latency: done is high in the cycle following edge 4*DWELL*REPEAT+1, counted from the start-accept edge (edge 0).
  - Example: DWELL=2, REPEAT=1 gives done after edge 9.
- Ignored inputs:
  - start in RUN or DONE is ignored, with no queuing.
  - gate_sel changes after acceptance are ignored.
- Expected values per vector 00,01,10,11:
  - AND 0001, OR 0111, NAND 1110, NOR 1000, XOR 0110, XNOR 1001.
- Reset mid-run: the run aborts immediately to reset values. No done pulse is generated.

Optional Feature:
- Macro: GATE_TT_FIRST_FAIL_EN.
- When defined, the block adds two output ports:
  - fail_valid (1 bit): reset 0, cleared on start accept, set on the first mismatch of a run, then held.
  - fail_vec (2 bits): {A,B} of the first mismatching vector; reset 00, cleared on start accept; frozen once fail_valid=1.
- An illegal gate_sel leaves fail_valid=0.
- When not defined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Correct NOR model, gate_sel=3, DWELL=2, REPEAT=1, start pulse at edge 0 -> A/B step 00,01,10,11 every 2 cycles; done pulses after edge 9; pass=1, err_count=0.
- dut_out tied 0, gate_sel=3 (NOR) -> err_count=1, pass=0; with the macro defined, fail_valid=1 and fail_vec=00.
- dut_out tied 1, gate_sel=0 (AND), REPEAT=2 -> err_count=6, pass=0; done after edge 17.
- gate_sel=7 with start -> done pulse after edge 1, err_count=all-ones (4'hF), pass=0, busy never high.
- start re-pulsed at edge 4 during RUN -> ignored, and done still follows edge 9. Then rst_n pulled low at cycle 6 of a new run -> outputs return to reset values immediately, with no done pulse.
- Correct XOR model -> pass=1; then start again with dut_out tied 0 -> pass stays 1 until the second start is accepted, then ends at pass=0 with err_count=2.
